// File: rtl/turbo_op_scheduler_pkg.sv
// Shared constants and types for the Turbo PIFO root-engine op scheduler.
package turbo_pkg;

    localparam int PTW_DEF   = 16;
    localparam int MTW_DEF   = 32;
    localparam int ADW_DEF   = 16;
    localparam int ROOT_ADDR = 0;

    localparam logic OP_PUSH = 1'b0;
    localparam logic OP_POP  = 1'b1;

    typedef enum logic {
        READY = 1'b0,
        GAP   = 1'b1
    } sched_state_t;

    typedef struct packed {
        logic [MTW_DEF-1:0] meta;
        logic [PTW_DEF-1:0] prio;
    } elem_t;

endpackage

// File: rtl/turbo_op_scheduler_rr_arb2.sv
// Two-requester round-robin grant; requester 0 is push, requester 1 is pop.
module turbo_rr_arb2
    import turbo_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_elig,
    input  logic [1:0] i_valid,
    output logic [1:0] o_ready
);

    logic ptr_q;
    logic ptr_d;
    logic contend;

    // Pointer names the favoured requester; after a contended grant it flips away from the winner.
    always_comb begin
        contend    = &(i_elig & i_valid);
        o_ready[0] = i_elig[0] && !(i_elig[1] && i_valid[1] && ptr_q);
        o_ready[1] = i_elig[1] && !(i_elig[0] && i_valid[0] && !ptr_q);
        ptr_d      = contend ? ~ptr_q : ptr_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/turbo_op_scheduler.sv
// Push/pop sequencer for the root Turbo_Engine: arbitration, post-pop gap, occupancy, result return.
// Optional statistics counters are enabled by defining TURBO_SCHED_STATS_EN.
module turbo_op_scheduler
    import turbo_pkg::*;
#(
    parameter  int PTW      = PTW_DEF,
    parameter  int MTW      = MTW_DEF,
    parameter  int ADW      = ADW_DEF,
    parameter  int CAPACITY = 340,
    parameter  int POP_GAP  = 2,
    localparam int OCW      = $clog2(CAPACITY + 1)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_push_valid,
    input  logic [MTW+PTW-1:0]   i_push_data,
    output logic                 o_push_ready,
    input  logic                 i_pop_valid,
    output logic                 o_pop_ready,
    output logic                 o_pop_res_valid,
    output logic [MTW+PTW-1:0]   o_pop_res_data,
    output logic                 o_eng_valid,
    output logic                 o_eng_op,
    output logic [MTW+PTW-1:0]   o_eng_data,
    output logic [ADW-1:0]       o_eng_addr,
    input  logic                 i_eng_res_valid,
    input  logic [MTW+PTW-1:0]   i_eng_res_data,
    output logic [OCW-1:0]       o_occupancy,
    output logic                 o_full,
`ifdef TURBO_SCHED_STATS_EN
    output logic [31:0]          o_stat_push_cnt,
    output logic [31:0]          o_stat_pop_cnt,
    output logic [31:0]          o_stat_stall_cnt,
`endif
    output logic                 o_empty
);

    localparam int DW = MTW + PTW;

    sched_state_t   state_q, state_d;
    logic [3:0]     gap_cnt_q, gap_cnt_d;
    logic [OCW-1:0] occ_q, occ_d;
    logic           eng_valid_q, eng_valid_d;
    logic           eng_op_q, eng_op_d;
    logic [DW-1:0]  eng_data_q, eng_data_d;
    logic           res_valid_q, res_valid_d;
    logic [DW-1:0]  res_data_q, res_data_d;

    logic       full;
    logic       empty;
    logic       push_ok;
    logic       pop_ok;
    logic [1:0] arb_ready;
    logic       push_ready;
    logic       pop_ready;
    logic       push_acc;
    logic       pop_acc;

    assign full    = (occ_q == OCW'(CAPACITY));
    assign empty   = (occ_q == '0);
    assign push_ok = (state_q == READY) && !full;
    assign pop_ok  = (state_q == READY) && !empty;

    turbo_rr_arb2 u_arb (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_elig  ({pop_ok, push_ok}),
        .i_valid ({i_pop_valid, i_push_valid}),
        .o_ready (arb_ready)
    );

    assign push_ready = arb_ready[0] && !i_rst;
    assign pop_ready  = arb_ready[1] && !i_rst;
    assign push_acc   = i_push_valid && push_ready;
    assign pop_acc    = i_pop_valid && pop_ready;

    always_comb begin
        state_d     = state_q;
        gap_cnt_d   = gap_cnt_q;
        occ_d       = occ_q;
        eng_valid_d = push_acc || pop_acc;
        eng_op_d    = pop_acc ? OP_POP : OP_PUSH;
        eng_data_d  = push_acc ? i_push_data : '0;
        res_valid_d = i_eng_res_valid;
        res_data_d  = i_eng_res_data;
        if (push_acc) begin
            occ_d = occ_q + 1'b1;
        end else if (pop_acc) begin
            occ_d = occ_q - 1'b1;
        end
        case (state_q)
            READY: begin
                if (pop_acc) begin
                    state_d   = GAP;
                    gap_cnt_d = 4'(POP_GAP);
                end
            end
            GAP: begin
                gap_cnt_d = gap_cnt_q - 1'b1;
                if (gap_cnt_q == 4'd1) begin
                    state_d = READY;
                end
            end
            default: state_d = READY;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= READY;
            gap_cnt_q   <= '0;
            occ_q       <= '0;
            eng_valid_q <= 1'b0;
            eng_op_q    <= OP_PUSH;
            eng_data_q  <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            gap_cnt_q   <= gap_cnt_d;
            occ_q       <= occ_d;
            eng_valid_q <= eng_valid_d;
            eng_op_q    <= eng_op_d;
            eng_data_q  <= eng_data_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end

    // Every output is forced low while reset is held, including flags derived from occupancy.
    assign o_push_ready    = push_ready;
    assign o_pop_ready     = pop_ready;
    assign o_eng_valid     = eng_valid_q && !i_rst;
    assign o_eng_op        = eng_op_q && !i_rst;
    assign o_eng_data      = i_rst ? '0 : eng_data_q;
    assign o_eng_addr      = ADW'(ROOT_ADDR);
    assign o_pop_res_valid = res_valid_q && !i_rst;
    assign o_pop_res_data  = i_rst ? '0 : res_data_q;
    assign o_occupancy     = i_rst ? '0 : occ_q;
    assign o_full          = full && !i_rst;
    assign o_empty         = empty && !i_rst;

`ifdef TURBO_SCHED_STATS_EN
    logic [31:0] push_cnt_q, push_cnt_d;
    logic [31:0] pop_cnt_q, pop_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic        stall;

    // A stall is a cycle with some request pending but no acceptance.
    always_comb begin
        stall       = (i_push_valid || i_pop_valid) && !push_acc && !pop_acc;
        push_cnt_d  = push_cnt_q;
        pop_cnt_d   = pop_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (push_acc && (push_cnt_q != '1)) push_cnt_d = push_cnt_q + 1'b1;
        if (pop_acc && (pop_cnt_q != '1)) pop_cnt_d = pop_cnt_q + 1'b1;
        if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            push_cnt_q  <= '0;
            pop_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            push_cnt_q  <= push_cnt_d;
            pop_cnt_q   <= pop_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign o_stat_push_cnt  = i_rst ? '0 : push_cnt_q;
    assign o_stat_pop_cnt   = i_rst ? '0 : pop_cnt_q;
    assign o_stat_stall_cnt = i_rst ? '0 : stall_cnt_q;
`endif

endmodule
